// File: rtl/processor_pkg.sv
// Shared processor definitions.
//   arb_state_t     : memory-port arbiter FSM states
//   REQ_IF / REQ_LS : requester identifiers (fetch / load-store)
//   DATA_W_DEF / ADDR_W_DEF : datapath widths shared across the core
package processor_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select.
//   clk, rst : clock, asynchronous active-high reset
//   req_if   : fetch request
//   req_ls   : load/store request
//   grant    : pulse when the current winner is actually granted
//   winner   : combinational winner (REQ_IF / REQ_LS)
module rr_arbiter2
    import processor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_ls,
    input  logic grant,
    output logic winner
);

    // Requester that wins the next tie; always the one not granted last.
    logic prio;

    always_comb begin
        winner = REQ_IF;
        if (req_if && req_ls) begin
            winner = prio;
        end else if (req_ls) begin
            winner = REQ_LS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= REQ_IF;
        end else if (grant) begin
            prio <= ~winner;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between instruction fetch and load/store.
// One transaction at a time: IDLE samples requests, ACCESS strobes the
// memory for one cycle, WAIT spends MEM_LAT cycles for the read data, then
// the granted requester sees a one-cycle rvalid pulse back in IDLE.
//   clk_in, rst_in          : clock, asynchronous active-high reset
//   if_req/addr_in          : fetch request (read only)
//   if_gnt/rvalid/rdata_out : fetch grant, completion, read data
//   ls_req/we/addr/wdata_in : load/store request
//   ls_gnt/rvalid/rdata_out : load/store grant, completion/ack, read data
//   mem_en/we/addr/wdata_out, mem_rdata_in : memory port
//   busy_out                : high from ACCESS through the last WAIT cycle
// All outputs are registered. MEM_LAT legal range is 1..4.
module mem_port_arbiter
    import processor_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_gnt_out,
    output logic              if_rvalid_out,
    output logic [DATA_W-1:0] if_rdata_out,
    input  logic              ls_req_in,
    input  logic              ls_we_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_wdata_in,
    output logic              ls_gnt_out,
    output logic              ls_rvalid_out,
    output logic [DATA_W-1:0] ls_rdata_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic              busy_out
);

    localparam int CNT_W = 3;

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             grant;
    logic             winner;
    logic             last_wait;
    logic             cur_port;
    logic             cur_we;

    rr_arbiter2 u_rr (
        .clk    (clk_in),
        .rst    (rst_in),
        .req_if (if_req_in),
        .req_ls (ls_req_in),
        .grant  (grant),
        .winner (winner)
    );

    assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_in || ls_req_in) begin
                    grant    = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nx   = CNT_W'(MEM_LAT);
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Output registers are loaded from next-state decisions so that gnt and
    // the memory strobe appear in the ACCESS cycle and rvalid in the cycle
    // after the last WAIT. The memory address/wdata registers double as the
    // capture registers for the granted request.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            if_gnt_out    <= 1'b0;
            if_rvalid_out <= 1'b0;
            if_rdata_out  <= '0;
            ls_gnt_out    <= 1'b0;
            ls_rvalid_out <= 1'b0;
            ls_rdata_out  <= '0;
            mem_en_out    <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            busy_out      <= 1'b0;
            cur_port      <= REQ_IF;
            cur_we        <= 1'b0;
        end else begin
            if_gnt_out    <= grant && (winner == REQ_IF);
            ls_gnt_out    <= grant && (winner == REQ_LS);
            mem_en_out    <= grant;
            mem_we_out    <= grant && (winner == REQ_LS) && ls_we_in;
            busy_out      <= (state_nx != IDLE);
            if_rvalid_out <= last_wait && (cur_port == REQ_IF);
            ls_rvalid_out <= last_wait && (cur_port == REQ_LS);

            if (grant) begin
                cur_port <= winner;
                cur_we   <= (winner == REQ_LS) && ls_we_in;
                if (winner == REQ_LS) begin
                    mem_addr_out  <= ls_addr_in;
                    mem_wdata_out <= ls_wdata_in;
                end else begin
                    mem_addr_out  <= if_addr_in;
                end
            end

            // Write acks leave ls_rdata_out untouched.
            if (last_wait) begin
                if (cur_port == REQ_IF) begin
                    if_rdata_out <= mem_rdata_in;
                end else if (!cur_we) begin
                    ls_rdata_out <= mem_rdata_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt, if_rv;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt, ls_rv;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    // Latency-variant instances for the MEM_LAT=1 / MEM_LAT=4 fetch check.
    logic        r_req;
    logic [7:0]  r_addr;
    logic        a1_gnt, a1_rv, a1_lgnt, a1_lrv, a1_en, a1_we, a1_busy;
    logic [31:0] a1_rdata, a1_lrdata, a1_wdata;
    logic [7:0]  a1_addr;
    logic        a4_gnt, a4_rv, a4_lgnt, a4_lrv, a4_en, a4_we, a4_busy;
    logic [31:0] a4_rdata, a4_lrdata, a4_wdata;
    logic [7:0]  a4_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(L)) dut (
        .clk_in(clk), .rst_in(rst),
        .if_req_in(if_req), .if_addr_in(if_addr),
        .if_gnt_out(if_gnt), .if_rvalid_out(if_rv), .if_rdata_out(if_rdata),
        .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
        .ls_gnt_out(ls_gnt), .ls_rvalid_out(ls_rv), .ls_rdata_out(ls_rdata),
        .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
        .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata), .busy_out(busy)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(1)) u_l1 (
        .clk_in(clk), .rst_in(rst),
        .if_req_in(r_req), .if_addr_in(r_addr),
        .if_gnt_out(a1_gnt), .if_rvalid_out(a1_rv), .if_rdata_out(a1_rdata),
        .ls_req_in(1'b0), .ls_we_in(1'b0), .ls_addr_in(8'h00), .ls_wdata_in(32'h0),
        .ls_gnt_out(a1_lgnt), .ls_rvalid_out(a1_lrv), .ls_rdata_out(a1_lrdata),
        .mem_en_out(a1_en), .mem_we_out(a1_we), .mem_addr_out(a1_addr),
        .mem_wdata_out(a1_wdata), .mem_rdata_in(32'h1000 + {24'h0, a1_addr}), .busy_out(a1_busy)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(4)) u_l4 (
        .clk_in(clk), .rst_in(rst),
        .if_req_in(r_req), .if_addr_in(r_addr),
        .if_gnt_out(a4_gnt), .if_rvalid_out(a4_rv), .if_rdata_out(a4_rdata),
        .ls_req_in(1'b0), .ls_we_in(1'b0), .ls_addr_in(8'h00), .ls_wdata_in(32'h0),
        .ls_gnt_out(a4_lgnt), .ls_rvalid_out(a4_lrv), .ls_rdata_out(a4_lrdata),
        .mem_en_out(a4_en), .mem_we_out(a4_we), .mem_addr_out(a4_addr),
        .mem_wdata_out(a4_wdata), .mem_rdata_in(32'h1000 + {24'h0, a4_addr}), .busy_out(a4_busy)
    );

    // Memory model: mem[k] = 0x1000+k after init; read data valid L cycles
    // after the strobe cycle, a poison value otherwise.
    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h1000 + 32'(k);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[0] <= mem_en ? mem[mem_addr] : 32'hBAD0_0000;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[L-1];

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [7];

    function automatic logic [6:0] ctl();
        return {if_gnt, if_rv, ls_gnt, ls_rv, mem_en, mem_we, busy};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ctl(input string nm, input logic [6:0] e);
        chk(nm, {57'd0, ctl()}, {57'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] gnt_code(input logic port, input logic we);
        return port ? (we ? 7'b0010111 : 7'b0010101) : 7'b1000101;
    endfunction

    // One complete single-requester transaction starting from IDLE.
    task automatic run_txn(input string nm, input logic port, input logic we,
                           input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        if (port) begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        tick();
        chk_ctl({nm, " gnt"}, gnt_code(port, we));
        chk({nm, " addr"}, {56'd0, mem_addr}, {56'd0, a});
        if (we) chk({nm, " wdata"}, {32'd0, mem_wdata}, {32'd0, d});
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (L) begin
            tick();
            chk_ctl({nm, " busy"}, 7'b0000001);
        end
        tick();
        chk_ctl({nm, " rvalid"}, port ? 7'b0001000 : 7'b0100000);
        chk({nm, " rdata"}, {32'd0, port ? ls_rdata : if_rdata}, {32'd0, exp_rd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c, g_cyc, rv_cyc, idle_from;
        logic        last, w_port, w_we;
        logic [7:0]  w_addr;
        logic [31:0] w_wdata, w_rd, e_if, e_ls;
        logic [31:0] mm [256];
        logic [6:0]  e_ctl;

        rst = 1'b1; init = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        r_req = 1'b0; r_addr = '0;
        tick();
        init = 1'b0;
        chk_ctl("reset ctl", 7'b0);
        chk("reset rdata", {if_rdata, ls_rdata}, 64'd0);
        chk("reset bus", {24'd0, mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;

        // Table-driven single-requester transactions.
        vt[0] = '{1'b0, 1'b0, 8'h05, 32'h0,        32'h0000_1005};
        vt[1] = '{1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 32'h0000_0000};
        vt[2] = '{1'b1, 1'b0, 8'h20, 32'h0,        32'hDEADBEEF};
        vt[3] = '{1'b1, 1'b1, 8'h21, 32'hCAFEF00D, 32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b0, 8'h21, 32'h0,        32'hCAFEF00D};
        vt[5] = '{1'b1, 1'b0, 8'hFF, 32'h0,        32'h0000_10FF};
        vt[6] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'h0000_1000};
        for (int v = 0; v < 7; v++) begin
            run_txn($sformatf("vec%0d", v), vt[v].port, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].exp_rd);
        end

        // Both requesters held high from reset: IF, LS, IF, LS.
        rst = 1'b1; tick(); rst = 1'b0;
        if_req = 1'b1; if_addr = 8'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_ctl("rr gnt", (k % 2 == 0) ? 7'b1000101 : 7'b0010101);
            repeat (L) begin
                tick();
                chk_ctl("rr busy", 7'b0000001);
            end
            tick();
            if (k == 3) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
            chk_ctl("rr rvalid", (k % 2 == 0) ? 7'b0100000 : 7'b0001000);
            chk("rr rdata", {32'd0, (k % 2 == 0) ? if_rdata : ls_rdata},
                {32'd0, (k % 2 == 0) ? 32'h1010 : 32'h1011});
        end

        // LSU request rising during a fetch WAIT is served after the fetch.
        if_req = 1'b1; if_addr = 8'h07;
        tick();
        chk_ctl("busy-req if gnt", 7'b1000101);
        if_req = 1'b0;
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h08;
        tick();
        chk_ctl("busy-req wait", 7'b0000001);
        tick();
        chk_ctl("busy-req if rvalid", 7'b0100000);
        chk("busy-req if rdata", {32'd0, if_rdata}, {32'd0, 32'h1007});
        tick();
        chk_ctl("busy-req ls gnt", 7'b0010101);
        chk("busy-req ls addr", {56'd0, mem_addr}, {56'd0, 8'h08});
        ls_req = 1'b0;
        repeat (L) tick();
        tick();
        chk_ctl("busy-req ls rvalid", 7'b0001000);
        chk("busy-req ls rdata", {32'd0, ls_rdata}, {32'd0, 32'h1008});

        // Asynchronous reset in the middle of WAIT drops the transaction.
        if_req = 1'b1; if_addr = 8'h09;
        tick();
        chk_ctl("midrst gnt", 7'b1000101);
        if_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk_ctl("midrst ctl", 7'b0);
        chk("midrst rdata", {if_rdata, ls_rdata}, 64'd0);
        chk("midrst bus", {24'd0, mem_addr, mem_wdata}, 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_ctl("midrst quiet", 7'b0);
        end
        if_req = 1'b1; if_addr = 8'h0A;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h0B;
        tick();
        chk_ctl("midrst dual gnt", 7'b1000101);
        if_req = 1'b0;
        repeat (L) tick();
        tick();
        chk_ctl("midrst if rvalid", 7'b0100000);
        chk("midrst if rdata", {32'd0, if_rdata}, {32'd0, 32'h100A});
        tick();
        chk_ctl("midrst ls gnt", 7'b0010101);
        ls_req = 1'b0;
        repeat (L) tick();
        tick();
        chk_ctl("midrst ls rvalid", 7'b0001000);
        chk("midrst ls rdata", {32'd0, ls_rdata}, {32'd0, 32'h100B});

        // Randomized traffic against a transaction-timeline model.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 256; k++) mm[k] = 32'h1000 + 32'(k);
        c = 0; g_cyc = -1; rv_cyc = -1; idle_from = 0;
        last = 1'b1; w_port = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = '0; w_rd = '0;
        e_if = '0; e_ls = '0;
        for (int i = 0; i < 3000; i++) begin
            if (c == g_cyc) begin
                if (w_port) ls_req = 1'b0;
                else        if_req = 1'b0;
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = 8'h40 + 8'($urandom_range(0, 15));
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = 8'h40 + 8'($urandom_range(0, 15));
                ls_wdata = $urandom;
            end
            if (c >= idle_from && (if_req || ls_req)) begin
                w_port = (if_req && ls_req) ? ~last : ls_req;
                last = w_port;
                w_we = w_port && ls_we;
                w_addr = w_port ? ls_addr : if_addr;
                w_wdata = ls_wdata;
                if (w_we) mm[w_addr] = ls_wdata;
                else      w_rd = mm[w_addr];
                g_cyc = c + 1;
                rv_cyc = c + 2 + L;
                idle_from = rv_cyc;
            end
            tick();
            c++;
            if (c == rv_cyc && !w_we) begin
                if (w_port) e_ls = w_rd;
                else        e_if = w_rd;
            end
            e_ls = e_ls;
            e_ctl = {(c == g_cyc) && !w_port, (c == rv_cyc) && !w_port,
                     (c == g_cyc) && w_port,  (c == rv_cyc) && w_port,
                     (c == g_cyc), (c == g_cyc) && w_we,
                     (c >= g_cyc) && (c < rv_cyc)};
            chk_ctl("rand ctl", e_ctl);
            chk("rand rdata", {if_rdata, ls_rdata}, {e_if, e_ls});
            if (c == g_cyc) begin
                chk("rand addr", {56'd0, mem_addr}, {56'd0, w_addr});
                if (w_we) chk("rand wdata", {32'd0, mem_wdata}, {32'd0, w_wdata});
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (L + 3) tick();

        // Fetch of 0x05 on MEM_LAT=1 and MEM_LAT=4 builds.
        r_req = 1'b1; r_addr = 8'h05;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) r_req = 1'b0;
            chk("lat1 ctl", {57'd0, a1_gnt, a1_rv, a1_lgnt, a1_lrv, a1_en, a1_we, a1_busy},
                {57'd0, k == 1, k == 3, 1'b0, 1'b0, k == 1, 1'b0, (k >= 1) && (k < 3)});
            chk("lat4 ctl", {57'd0, a4_gnt, a4_rv, a4_lgnt, a4_lrv, a4_en, a4_we, a4_busy},
                {57'd0, k == 1, k == 6, 1'b0, 1'b0, k == 1, 1'b0, (k >= 1) && (k < 6)});
            if (k == 3) chk("lat1 rdata", {32'd0, a1_rdata}, {32'd0, 32'h1005});
            if (k == 6) chk("lat4 rdata", {32'd0, a4_rdata}, {32'd0, 32'h1005});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
